// File: rtl/vend_sequencer.sv
// vend_sequencer: coin/select transaction controller for the vending path.
// Accumulates credit from one-cycle coin pulses, runs the dispenser req/ack
// handshake and pays change or refunds through the hopper req/ack handshake.
// Every output is registered and follows the sampling edge by one cycle.
//
// Optional build macro: VEND_CANCEL_EN adds a cancel input that refunds the
// current credit from CREDIT.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no credit, waiting for the first coin
// CREDIT   | holding credit, accepting coins, waiting for select/timeout
// DISPENSE | disp_req high, waiting for the dispenser to acknowledge
// CHANGE   | paying out the remaining credit after a sale
// REFUND   | paying out the whole credit after timeout (or cancel)
module vend_sequencer #(
  parameter int PRICE      = 150,
  parameter int MAX_CREDIT = 300,
  parameter int CW         = 10,
  parameter int TIMEOUT    = 1000,
  parameter int TW         = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coin50,
  input  logic          coin100,
  input  logic          sel,
  input  logic          disp_ack,
  input  logic          chg_ack,
`ifdef VEND_CANCEL_EN
  input  logic          cancel,
`endif
  output logic          disp_req,
  output logic          chg_req,
  output logic          chg_sel,
  output logic          coin_rej,
  output logic          coin_en,
  output logic [CW-1:0] credit,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_CREDIT   = 3'b001,
    S_DISPENSE = 3'b010,
    S_CHANGE   = 3'b011,
    S_REFUND   = 3'b100
  } state_t;

  localparam logic [CW-1:0] C50      = CW'(50);
  localparam logic [CW-1:0] C100     = CW'(100);
  localparam logic [CW-1:0] PRICE_C  = CW'(PRICE);
  localparam logic [CW:0]   MAX_W    = (CW+1)'(MAX_CREDIT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          disp_req_d, chg_req_d, chg_sel_d, coin_rej_d, coin_en_d;
  logic          cancel_w;
  logic          coin_any;
  logic [CW:0]   sum50, sum100;

`ifdef VEND_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = 1'b0;
`endif

  assign coin_any = coin50 | coin100;
  // One spare bit so an overflowing coin is caught instead of wrapping.
  assign sum50    = {1'b0, credit_q} + {1'b0, C50};
  assign sum100   = {1'b0, credit_q} + {1'b0, C100};

  // Next-state, credit, timeout and registered-output values.
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    tmo_d      = '0;
    coin_rej_d = 1'b0;

    case (state_q)
      S_IDLE, S_CREDIT: begin
        if (state_q == S_CREDIT && cancel_w) begin
          state_d    = S_REFUND;
          coin_rej_d = coin_any;
        end else if (coin100) begin
          if (sum100 <= MAX_W) begin
            credit_d = sum100[CW-1:0];
            state_d  = S_CREDIT;
          end else begin
            coin_rej_d = 1'b1;
          end
          // Only one coin is taken per cycle; the 50 goes back to the user.
          if (coin50) coin_rej_d = 1'b1;
        end else if (coin50) begin
          if (sum50 <= MAX_W) begin
            credit_d = sum50[CW-1:0];
            state_d  = S_CREDIT;
          end else begin
            coin_rej_d = 1'b1;
          end
        end else if (state_q == S_CREDIT) begin
          if (sel) begin
            if (credit_q >= PRICE_C) begin
              credit_d = credit_q - PRICE_C;
              state_d  = S_DISPENSE;
            end
          end else if (tmo_q == TMO_LAST) begin
            state_d = S_REFUND;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
      end
      S_DISPENSE: begin
        coin_rej_d = coin_any;
        if (disp_req && disp_ack) begin
          state_d = (credit_q != '0) ? S_CHANGE : S_IDLE;
        end
      end
      S_CHANGE, S_REFUND: begin
        coin_rej_d = coin_any;
        if (credit_q == '0) begin
          state_d = S_IDLE;
        end else if (chg_req && chg_ack) begin
          credit_d = chg_sel ? (credit_q - C100) : (credit_q - C50);
          if (credit_d == '0) state_d = S_IDLE;
        end
      end
      default: begin
        // Illegal encodings recover to an empty IDLE.
        state_d  = S_IDLE;
        credit_d = '0;
      end
    endcase

    disp_req_d = (state_d == S_DISPENSE);
    chg_req_d  = (state_d == S_CHANGE || state_d == S_REFUND) && (credit_d != '0);
    chg_sel_d  = chg_req_d && (credit_d >= C100);
    coin_en_d  = (state_d == S_IDLE || state_d == S_CREDIT);
  end

  // State, credit, timeout counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      tmo_q    <= '0;
      disp_req <= 1'b0;
      chg_req  <= 1'b0;
      chg_sel  <= 1'b0;
      coin_rej <= 1'b0;
      coin_en  <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      tmo_q    <= tmo_d;
      disp_req <= disp_req_d;
      chg_req  <= chg_req_d;
      chg_sel  <= chg_sel_d;
      coin_rej <= coin_rej_d;
      coin_en  <= coin_en_d;
    end
  end

  assign credit = credit_q;
  assign state  = state_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: directed vector table plus
// hand-written timeout (and, when VEND_CANCEL_EN is defined, cancel) sequences.
module tb_vend_sequencer;

  localparam int TIMEOUT = 1000;

  logic       clk = 1'b0;
  logic       rst, coin50, coin100, sel, disp_ack, chg_ack;
`ifdef VEND_CANCEL_EN
  logic       cancel;
`endif
  logic       disp_req, chg_req, chg_sel, coin_rej, coin_en;
  logic [9:0] credit;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  // inputs  = {rst, coin50, coin100, sel, disp_ack, chg_ack, cancel}
  // outputs = {disp_req, chg_req, chg_sel, coin_rej, coin_en}
  typedef struct {
    logic [6:0] in;
    logic [2:0] st;
    logic [9:0] cr;
    logic [4:0] outs;
  } vec_t;

  vec_t vecs[$];

  vend_sequencer #(
    .PRICE(150), .MAX_CREDIT(300), .CW(10), .TIMEOUT(TIMEOUT), .TW(10)
  ) dut (
    .clk(clk), .rst(rst), .coin50(coin50), .coin100(coin100), .sel(sel),
    .disp_ack(disp_ack), .chg_ack(chg_ack),
`ifdef VEND_CANCEL_EN
    .cancel(cancel),
`endif
    .disp_req(disp_req), .chg_req(chg_req), .chg_sel(chg_sel),
    .coin_rej(coin_rej), .coin_en(coin_en), .credit(credit), .state(state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [6:0] in, logic [2:0] st, int cr, logic [4:0] outs);
    vec_t v;
    v.in   = in;
    v.st   = st;
    v.cr   = 10'(cr);
    v.outs = outs;
    return v;
  endfunction

  // Drive one cycle of inputs at the falling edge, check just after the rising edge.
  task automatic step(input vec_t v, input string name, input bit do_check);
    logic [17:0] act, exp;
    @(negedge clk);
    rst      = v.in[6];
    coin50   = v.in[5];
    coin100  = v.in[4];
    sel      = v.in[3];
    disp_ack = v.in[2];
    chg_ack  = v.in[1];
`ifdef VEND_CANCEL_EN
    cancel   = v.in[0];
`endif
    @(posedge clk);
    #1;
    if (do_check) begin
      act = {state, credit, disp_req, chg_req, chg_sel, coin_rej, coin_en};
      exp = {v.st, v.cr, v.outs};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: got state=%0d credit=%0d dreq/creq/csel/rej/en=%b, want state=%0d credit=%0d dreq/creq/csel/rej/en=%b",
                 name, state, credit, act[4:0], v.st, v.cr, v.outs);
      end
    end
  endtask

  initial begin
    rst = 1'b1; coin50 = 1'b0; coin100 = 1'b0; sel = 1'b0;
    disp_ack = 1'b0; chg_ack = 1'b0;
`ifdef VEND_CANCEL_EN
    cancel = 1'b0;
`endif

    // Reset and exact-price sale.
    vecs.push_back(mk(7'b1000000, 3'd0,   0, 5'b00000));
    vecs.push_back(mk(7'b0000000, 3'd0,   0, 5'b00001));
    vecs.push_back(mk(7'b0010000, 3'd1, 100, 5'b00001));
    vecs.push_back(mk(7'b0100000, 3'd1, 150, 5'b00001));
    vecs.push_back(mk(7'b0001000, 3'd2,   0, 5'b10000));
    vecs.push_back(mk(7'b0000000, 3'd2,   0, 5'b10000));
    vecs.push_back(mk(7'b0000000, 3'd2,   0, 5'b10000));
    vecs.push_back(mk(7'b0000100, 3'd0,   0, 5'b00001));
    // Overpay: 300 in, 150 change as 100 then 50.
    vecs.push_back(mk(7'b0010000, 3'd1, 100, 5'b00001));
    vecs.push_back(mk(7'b0010000, 3'd1, 200, 5'b00001));
    vecs.push_back(mk(7'b0010000, 3'd1, 300, 5'b00001));
    vecs.push_back(mk(7'b0001000, 3'd2, 150, 5'b10000));
    vecs.push_back(mk(7'b0000100, 3'd3, 150, 5'b01100));
    vecs.push_back(mk(7'b0000000, 3'd3, 150, 5'b01100));
    vecs.push_back(mk(7'b0000010, 3'd3,  50, 5'b01000));
    vecs.push_back(mk(7'b0000010, 3'd0,   0, 5'b00001));
    // Overflow rejection, exact-ceiling acceptance.
    vecs.push_back(mk(7'b0010000, 3'd1, 100, 5'b00001));
    vecs.push_back(mk(7'b0010000, 3'd1, 200, 5'b00001));
    vecs.push_back(mk(7'b0100000, 3'd1, 250, 5'b00001));
    vecs.push_back(mk(7'b0010000, 3'd1, 250, 5'b00011));
    vecs.push_back(mk(7'b0100000, 3'd1, 300, 5'b00001));
    vecs.push_back(mk(7'b0100000, 3'd1, 300, 5'b00011));
    // Coins while dispensing, then reset mid-change.
    vecs.push_back(mk(7'b0001000, 3'd2, 150, 5'b10000));
    vecs.push_back(mk(7'b0100000, 3'd2, 150, 5'b10010));
    vecs.push_back(mk(7'b0010100, 3'd3, 150, 5'b01110));
    vecs.push_back(mk(7'b0000010, 3'd3,  50, 5'b01000));
    vecs.push_back(mk(7'b1000000, 3'd0,   0, 5'b00000));
    vecs.push_back(mk(7'b0000010, 3'd0,   0, 5'b00001));
    // Simultaneous coins, insufficient select, select with coin.
    vecs.push_back(mk(7'b0110000, 3'd1, 100, 5'b00011));
    vecs.push_back(mk(7'b0000000, 3'd1, 100, 5'b00001));
    vecs.push_back(mk(7'b0001000, 3'd1, 100, 5'b00001));
    vecs.push_back(mk(7'b0101000, 3'd1, 150, 5'b00001));
    vecs.push_back(mk(7'b0001000, 3'd2,   0, 5'b10000));
    vecs.push_back(mk(7'b0000100, 3'd0,   0, 5'b00001));
    // Acks with no request pending are ignored.
    vecs.push_back(mk(7'b0000110, 3'd0,   0, 5'b00001));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], $sformatf("vec%0d", i), 1'b1);
    end

    // Timeout: credit 100, insufficient select, then TIMEOUT idle cycles.
    step(mk(7'b1000000, 3'd0,   0, 5'b00000), "tmo_rst", 1'b1);
    step(mk(7'b0010000, 3'd1, 100, 5'b00001), "tmo_coin", 1'b1);
    step(mk(7'b0001000, 3'd1, 100, 5'b00001), "tmo_sel", 1'b1);
    for (int i = 0; i < TIMEOUT - 2; i++) begin
      step(mk(7'b0000000, 3'd1, 100, 5'b00001), "tmo_wait", 1'b0);
    end
    step(mk(7'b0000000, 3'd1, 100, 5'b00001), "tmo_last_credit", 1'b1);
    step(mk(7'b0000000, 3'd4, 100, 5'b01100), "tmo_refund", 1'b1);
    step(mk(7'b0000000, 3'd4, 100, 5'b01100), "tmo_refund_hold", 1'b1);
    step(mk(7'b0000010, 3'd0,   0, 5'b00001), "tmo_paid", 1'b1);

`ifdef VEND_CANCEL_EN
    // Cancel with a coin in the same cycle, refund 100 then 50.
    step(mk(7'b0100000, 3'd1,  50, 5'b00001), "cxl_c50", 1'b1);
    step(mk(7'b0010000, 3'd1, 150, 5'b00001), "cxl_c100", 1'b1);
    step(mk(7'b0100001, 3'd4, 150, 5'b01110), "cxl_cancel", 1'b1);
    step(mk(7'b0000010, 3'd4,  50, 5'b01000), "cxl_ack1", 1'b1);
    step(mk(7'b0000010, 3'd0,   0, 5'b00001), "cxl_ack2", 1'b1);
    step(mk(7'b0000001, 3'd0,   0, 5'b00001), "cxl_idle", 1'b1);
    // Cancel wins over a valid select.
    step(mk(7'b0010000, 3'd1, 100, 5'b00001), "cxl2_c100", 1'b1);
    step(mk(7'b0100000, 3'd1, 150, 5'b00001), "cxl2_c50", 1'b1);
    step(mk(7'b0001001, 3'd4, 150, 5'b01100), "cxl2_sel", 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
- Transaction controller for the coin-operated vending path.
- Sits downstream of the per-button oneshot pulse generators; consumes one-cycle coin and select pulses.
- Accumulates credit and sequences the product dispenser through a req/ack handshake.
- Pays out change or refund to the coin hopper through a second req/ack handshake.

Parameters:
- PRICE, 150, product price in money units; must be a multiple of 50.
- MAX_CREDIT, 300, credit ceiling; must be a multiple of 50 and >= PRICE.
- CW, 10, credit register width.
- TIMEOUT, 1000, inactivity cycles in CREDIT before automatic refund.
- TW, 10, timeout counter width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- coin50  in  1  one-cycle pulse: 50-unit coin inserted.
- coin100  in  1  one-cycle pulse: 100-unit coin inserted.
- sel  in  1  one-cycle pulse: product select.
- disp_ack  in  1  dispenser done; level, sampled while disp_req=1.
- chg_ack  in  1  hopper ejected one coin; sampled while chg_req=1.
- disp_req  out  1  dispense request.
- chg_req  out  1  change coin request.
- chg_sel  out  1  coin type for the pending change request: 1 = 100 coin, 0 = 50 coin.
- coin_rej  out  1  one-cycle pulse: the inserted coin is rejected and returned mechanically.
- coin_en  out  1  coin acceptor enable.
- credit  out  CW  current credit.
- state  out  3  FSM state.

Behaviour:
- Reset values: state=IDLE, credit=0, timeout counter=0, and every other output 0.
- All outputs are registered; each responds one cycle after the sampling edge.

State encoding:
- IDLE=000, CREDIT=001, DISPENSE=010, CHANGE=011, REFUND=100.
- Unused codes return to IDLE on the next edge.

Coin enable:
- coin_en=1 only in IDLE and CREDIT.
- A coin pulse in any other state gives coin_rej=1 next cycle; credit is unchanged.

Coin acceptance (IDLE/CREDIT):
- An accepted coin adds its value to credit; IDLE moves to CREDIT.
- A coin that would make credit exceed MAX_CREDIT is rejected with coin_rej; credit is unchanged.
- coin50 and coin100 in the same cycle: coin100 is processed under the normal rules and coin50 is always rejected.

Select (CREDIT):
- sel with credit >= PRICE: credit -= PRICE and go to DISPENSE.
- sel with credit < PRICE: ignored.
- sel in the same cycle as any coin pulse: ignored; the coin is processed.
- sel in any other state: ignored.

Timeout (CREDIT):
- Counter clears on every accepted coin, every rejected coin and every sel.
- Otherwise the counter increments each cycle.
- When it reaches TIMEOUT-1, go to REFUND.

DISPENSE:
- disp_req=1 from the first cycle in DISPENSE.
- On the edge where disp_ack=1: disp_req drops next cycle; go to CHANGE if credit>0, else IDLE.

CHANGE/REFUND (identical payout):
- chg_req=1 while credit>0.
- chg_sel=1 if credit >= 100, else 0.
- On each chg_ack=1 edge, credit decreases by 100 or 50 per chg_sel.
- chg_req may stay high across back-to-back acks; chg_sel updates to match the new credit.
- When credit reaches 0, chg_req drops and state goes to IDLE.
- Ack inputs are ignored when the matching req=0.

Invariant and reset:
- credit is always a multiple of 50 and never exceeds MAX_CREDIT.
- rst asserted in any state, including mid-handshake, gives the reset values on the next edge; credit is lost by design.

Optional Feature:
- Macro: VEND_CANCEL_EN.
- Defined: adds input port cancel (1-bit pulse). In CREDIT, a cancel pulse goes to REFUND next cycle. cancel has priority over sel and over coins in the same cycle; a coin in that cycle is rejected with coin_rej. cancel in other states is ignored.
- Undefined: the port is absent; REFUND is reachable only by timeout.

Test Plan:
- Exact price: coin100, then coin50, then sel; disp_ack 3 cycles later -> credit goes 100, 150, then 0 in DISPENSE; disp_req high until ack; state returns to IDLE; no chg_req.
- Overpay: coin100 x3 (credit 300), sel, ack -> credit 150 after sel; CHANGE issues chg_sel=1 (100 coin) then chg_sel=0 (50 coin) over 2 acks; ends in IDLE.
- Overflow and simultaneous coins: credit 250, then coin100 -> coin_rej, credit stays 250; coin50 and coin100 together at credit 0 -> credit 100, coin_rej pulses once.
- Insufficient credit, then timeout: credit 100, sel -> ignored; no input for TIMEOUT cycles -> REFUND; one chg_sel=1 coin; IDLE.
- Coin during DISPENSE and reset mid-handshake: coin50 while disp_req=1 -> coin_rej, coin_en=0; rst during CHANGE -> all outputs 0, state IDLE next edge.
- VEND_CANCEL_EN: credit 150, cancel together with coin50 -> coin_rej; REFUND pays 100 then 50.
